// File: rtl/load_store_unit.sv
`default_nettype none
// ============================================================================
// Module      : load_store_unit
// Description : Multi-cycle load/store initiator between the MEM stage and a
//               word-wide, byte-enabled, synchronous-read data memory. It
//               splits misaligned accesses into two word transactions, uses
//               little-endian byte lanes, and returns sign/zero-extended load
//               data or store completion as a one-cycle response pulse.
// Ports       : clk, rst                        - clock, sync active-high reset
//               req_valid/ready/op/addr/wdata   - request handshake
//               rsp_valid/rdata/err             - response pulse and payload
//               mem_en/we/be/waddr/wdata/rdata  - data memory port
// Revision    : 1.0 - initial release
// ============================================================================
module load_store_unit #(
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [3:0]        req_op,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err,
    output logic              mem_en,
    output logic              mem_we,
    output logic [3:0]        mem_be,
    output logic [ADDR_W-3:0] mem_waddr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);

    localparam logic [2:0] c_IDLE   = 3'd0;
    localparam logic [2:0] c_ISSUE0 = 3'd1;
    localparam logic [2:0] c_ISSUE1 = 3'd2;
    localparam logic [2:0] c_CAP    = 3'd3;
    localparam logic [2:0] c_RESP   = 3'd4;

    logic [2:0]        r_state;
    logic [2:0]        w_next;
    logic [3:0]        r_op;
    logic [ADDR_W-1:0] r_addr;
    logic [31:0]       r_wdata;
    logic [31:0]       r_lo;
    logic [31:0]       r_rsp_rdata;
    logic              r_rsp_err;

    logic              w_accept;
    logic              w_store;
    logic              w_signed;
    logic [3:0]        w_mask;
    logic              w_split;
    logic [1:0]        w_off;
    logic [7:0]        w_be_wide;
    logic [63:0]       w_wdata_wide;
    logic [ADDR_W-3:0] w_waddr0;
    logic [ADDR_W-3:0] w_waddr1;
    logic [31:0]       w_lo;
    logic [23:0]       w_hi;
    logic [55:0]       w_cat;
    logic [31:0]       w_raw;
    logic [31:0]       w_load_data;

    assign w_accept = req_valid & req_ready;
    assign w_off    = r_addr[1:0];

    // Op decode from the latched request (bit 3 set means a legal op)
    assign w_store  = (r_op == 4'b1011) | (r_op[3:1] == 3'b111);
    assign w_signed = (r_op == 4'b1000) | (r_op == 4'b1001);

    always_comb begin
        w_mask = 4'b0001;
        case (r_op[2:0])
            3'b001, 3'b101, 3'b110: w_mask = 4'b0011;
            3'b010, 3'b111:         w_mask = 4'b1111;
            default:                w_mask = 4'b0001;
        endcase
    end

    assign w_split = ((w_mask == 4'b0011) && (w_off == 2'd3)) ||
                     ((w_mask == 4'b1111) && (w_off != 2'd0));

    // Shifting across a double-width window gives word0 in the low half and
    // the spill-over for word1 in the high half in one operation.
    assign w_be_wide    = {4'b0000, w_mask} << w_off;
    assign w_wdata_wide = {32'h0, r_wdata} << {w_off, 3'b000};

    assign w_waddr0 = r_addr[ADDR_W-1:2];
    assign w_waddr1 = w_waddr0 + {{(ADDR_W-3){1'b0}}, 1'b1};

    // Load assembly: in CAP the bus holds lo (non-split) or hi (split).
    // Only hi[23:0] can ever reach the result since the shift is at most 24.
    assign w_lo  = w_split ? r_lo : mem_rdata;
    assign w_hi  = w_split ? mem_rdata[23:0] : 24'h0;
    assign w_cat = {w_hi, w_lo};

    always_comb begin
        w_raw = w_cat[31:0];
        case (w_off)
            2'd1:    w_raw = w_cat[39:8];
            2'd2:    w_raw = w_cat[47:16];
            2'd3:    w_raw = w_cat[55:24];
            default: w_raw = w_cat[31:0];
        endcase
    end

    always_comb begin
        w_load_data = w_raw;
        if (w_mask == 4'b0001)
            w_load_data = {{24{w_signed & w_raw[7]}}, w_raw[7:0]};
        else if (w_mask == 4'b0011)
            w_load_data = {{16{w_signed & w_raw[15]}}, w_raw[15:0]};
    end

    // ---------------- state register ----------------
    always_ff @(posedge clk) begin
        if (rst)
            r_state <= c_IDLE;
        else
            r_state <= w_next;
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        w_next = r_state;
        case (r_state)
            c_IDLE:   if (w_accept) w_next = req_op[3] ? c_ISSUE0 : c_RESP;
            c_ISSUE0: w_next = w_split ? c_ISSUE1 : (w_store ? c_RESP : c_CAP);
            c_ISSUE1: w_next = w_store ? c_RESP : c_CAP;
            c_CAP:    w_next = c_RESP;
            c_RESP:   w_next = c_IDLE;
            default:  w_next = c_IDLE;
        endcase
    end

    // ---------------- request latch and response registers ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_op        <= 4'h0;
            r_addr      <= '0;
            r_wdata     <= 32'h0;
            r_lo        <= 32'h0;
            r_rsp_rdata <= 32'h0;
            r_rsp_err   <= 1'b0;
        end else begin
            if (w_accept) begin
                r_op    <= req_op;
                r_addr  <= req_addr;
                r_wdata <= req_wdata;
            end
            // Word0 read data is on the bus while word1 is being issued
            if ((r_state == c_ISSUE1) && !w_store)
                r_lo <= mem_rdata;
            // Response payload is loaded on entry to RESP and held afterwards
            if ((r_state != c_RESP) && (w_next == c_RESP)) begin
                r_rsp_err   <= (r_state == c_IDLE);
                r_rsp_rdata <= (r_state == c_CAP) ? w_load_data : 32'h0;
            end
        end
    end

    // ---------------- output decode ----------------
    always_comb begin
        req_ready = (r_state == c_IDLE);
        rsp_valid = (r_state == c_RESP);
        rsp_err   = (r_state == c_RESP) & r_rsp_err;
        rsp_rdata = r_rsp_rdata;
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_be    = 4'b0000;
        mem_waddr = '0;
        mem_wdata = 32'h0;
        if (r_state == c_ISSUE0) begin
            mem_en    = 1'b1;
            mem_we    = w_store;
            mem_be    = w_be_wide[3:0];
            mem_waddr = w_waddr0;
            mem_wdata = w_wdata_wide[31:0];
        end else if (r_state == c_ISSUE1) begin
            mem_en    = 1'b1;
            mem_we    = w_store;
            mem_be    = w_be_wide[7:4];
            mem_waddr = w_waddr1;
            mem_wdata = w_wdata_wide[63:32];
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_load_store_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_load_store_unit
// Description : Directed self-checking bench for load_store_unit with a
//               16-word byte-enabled synchronous-read memory model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_load_store_unit;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [3:0]  req_op;
    logic [5:0]  req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        mem_en;
    logic        mem_we;
    logic [3:0]  mem_be;
    logic [3:0]  mem_waddr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    load_store_unit #(.ADDR_W(6)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op    (req_op),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_be    (mem_be),
        .mem_waddr (mem_waddr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model
    logic [31:0] mem [0:15];
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) begin
                for (int b = 0; b < 4; b++)
                    if (mem_be[b]) mem[mem_waddr][8*b +: 8] <= mem_wdata[8*b +: 8];
            end else begin
                mem_rdata <= mem[mem_waddr];
            end
        end
    end

    // Access log
    typedef struct {
        logic        we;
        logic [3:0]  waddr;
        logic [3:0]  be;
        logic [31:0] data;
    } acc_t;
    acc_t acc_q[$];
    always @(negedge clk) begin
        if (mem_en) begin
            acc_t a;
            a.we = mem_we; a.waddr = mem_waddr; a.be = mem_be; a.data = mem_wdata;
            acc_q.push_back(a);
        end
    end

    int          total = 0;
    int          bad   = 0;
    int          lat;
    logic [31:0] r_data;
    logic        r_err;
    int          seen;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_acc(input string tag, input int i, input logic we,
                           input logic [3:0] wa, input logic [3:0] be, input logic [31:0] d);
        acc_t a;
        a.we = 1'bx; a.waddr = 4'hx; a.be = 4'hx; a.data = 32'hx;
        if (i < acc_q.size()) a = acc_q[i];
        chk({tag, ".we"},    {31'h0, a.we}, {31'h0, we});
        chk({tag, ".waddr"}, {28'h0, a.waddr}, {28'h0, wa});
        chk({tag, ".be"},    {28'h0, a.be}, {28'h0, be});
        if (we) chk({tag, ".wdata"}, a.data, d);
    endtask

    // Issue one request and wait (bounded) for its response.
    // lat = k means rsp_valid is sampled at accept edge T+k; lat = 0 means
    // no response arrived within the wait window.
    task automatic run(input logic [3:0] op, input logic [5:0] addr, input logic [31:0] wd);
        @(negedge clk);
        acc_q.delete();
        req_op = op; req_addr = addr; req_wdata = wd; req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        lat = 0; r_data = 32'hx; r_err = 1'bx;
        for (int n = 1; n <= 8; n++) begin
            @(negedge clk);
            if (rsp_valid) begin
                lat = n; r_data = rsp_rdata; r_err = rsp_err;
                break;
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = 32'h0;
        mem_rdata = 32'h0;
        rst = 1'b1; req_valid = 1'b0; req_op = 4'h0; req_addr = 6'h0; req_wdata = 32'h0;
        repeat (3) @(posedge clk);
        @(negedge clk);

        // Reset state
        chk("rst.req_ready", {31'h0, req_ready}, 32'd1);
        chk("rst.rsp_valid", {31'h0, rsp_valid}, 32'd0);
        chk("rst.rsp_err",   {31'h0, rsp_err},   32'd0);
        chk("rst.mem_en",    {31'h0, mem_en},    32'd0);
        chk("rst.mem_we",    {31'h0, mem_we},    32'd0);
        chk("rst.mem_be",    {28'h0, mem_be},    32'd0);
        chk("rst.mem_waddr", {28'h0, mem_waddr}, 32'd0);
        chk("rst.mem_wdata", mem_wdata, 32'd0);
        chk("rst.rsp_rdata", rsp_rdata, 32'd0);
        rst = 1'b0;

        // Aligned lw
        mem[1] = 32'h8899AABB;
        run(4'b1010, 6'h04, 32'h0);
        chk("lw04.lat",  lat, 32'd3);
        chk("lw04.data", r_data, 32'h8899AABB);
        chk("lw04.err",  {31'h0, r_err}, 32'd0);
        chk("lw04.nacc", acc_q.size(), 32'd1);
        chk_acc("lw04.a0", 0, 1'b0, 4'd1, 4'b1111, 32'h0);

        // sb into lane 1
        run(4'b1011, 6'h05, 32'h000000F0);
        chk("sb05.lat",  lat, 32'd2);
        chk("sb05.data", r_data, 32'h0);
        chk("sb05.nacc", acc_q.size(), 32'd1);
        chk_acc("sb05.a0", 0, 1'b1, 4'd1, 4'b0010, 32'h0000F000);

        run(4'b1000, 6'h05, 32'h0);
        chk("lb05.data", r_data, 32'hFFFFFFF0);
        chk("lb05.lat",  lat, 32'd3);
        run(4'b1100, 6'h05, 32'h0);
        chk("lbu05.data", r_data, 32'h000000F0);

        // Misaligned sw split across words 1 and 2
        run(4'b1111, 6'h07, 32'h11223344);
        chk("sw07.lat",  lat, 32'd3);
        chk("sw07.nacc", acc_q.size(), 32'd2);
        chk_acc("sw07.a0", 0, 1'b1, 4'd1, 4'b1000, 32'h44000000);
        chk_acc("sw07.a1", 1, 1'b1, 4'd2, 4'b0111, 32'h00112233);

        run(4'b1010, 6'h07, 32'h0);
        chk("lw07.lat",  lat, 32'd4);
        chk("lw07.data", r_data, 32'h11223344);

        // Split halfword loads across words 0 and 1
        mem[0] = 32'h80000000;
        mem[1] = 32'h000000FF;
        run(4'b1001, 6'h03, 32'h0);
        chk("lh03.lat",  lat, 32'd4);
        chk("lh03.data", r_data, 32'hFFFFFF80);
        chk("lh03.nacc", acc_q.size(), 32'd2);
        chk_acc("lh03.a0", 0, 1'b0, 4'd0, 4'b1000, 32'h0);
        chk_acc("lh03.a1", 1, 1'b0, 4'd1, 4'b0001, 32'h0);
        run(4'b1101, 6'h03, 32'h0);
        chk("lhu03.data", r_data, 32'h0000FF80);

        // Illegal op
        run(4'b0101, 6'h04, 32'hDEADBEEF);
        chk("ill.lat",   lat, 32'd1);
        chk("ill.err",   {31'h0, r_err}, 32'd1);
        chk("ill.data",  r_data, 32'h0);
        chk("ill.ready_during", {31'h0, req_ready}, 32'd0);
        @(negedge clk);
        chk("ill.ready_after", {31'h0, req_ready}, 32'd1);
        chk("ill.err_after",   {31'h0, rsp_err}, 32'd0);
        chk("ill.nacc", acc_q.size(), 32'd0);

        // Reset during ISSUE1 of a split load
        @(negedge clk);
        acc_q.delete();
        req_op = 4'b1010; req_addr = 6'h07; req_wdata = 32'h0; req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("rstmid.issue1_en",    {31'h0, mem_en}, 32'd1);
        chk("rstmid.issue1_waddr", {28'h0, mem_waddr}, 32'd2);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rstmid.ready",  {31'h0, req_ready}, 32'd1);
        chk("rstmid.mem_en", {31'h0, mem_en}, 32'd0);
        seen = 0;
        for (int n = 0; n < 4; n++) begin
            if (rsp_valid) seen++;
            @(negedge clk);
        end
        chk("rstmid.no_rsp", seen, 32'd0);

        run(4'b1010, 6'h04, 32'h0);
        chk("post_rst.lat",  lat, 32'd3);
        chk("post_rst.data", r_data, 32'h000000FF);

        // Address wrap: top word then word 0
        mem[15] = 32'hDDCCBBAA;
        run(4'b1010, 6'h3E, 32'h0);
        chk("wrap.lat",  lat, 32'd4);
        chk("wrap.data", r_data, 32'h0000DDCC);
        chk_acc("wrap.a0", 0, 1'b0, 4'd15, 4'b1100, 32'h0);
        chk_acc("wrap.a1", 1, 1'b0, 4'd0,  4'b0011, 32'h0);

        // rsp_rdata holds after the pulse
        @(negedge clk);
        chk("hold.rdata", rsp_rdata, 32'h0000DDCC);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/load_store_unit.md
# load_store_unit

Multi-cycle load/store initiator between the pipeline's MEM stage and a word-wide, byte-enabled, synchronous-read data memory. Accepts one access per handshake using the core's 4-bit `read_write` op code. Generates one or two word transactions, including misaligned splits, with little-endian byte lanes. Returns sign/zero-extended load data or store completion as a one-cycle response pulse.

## Interface
- `ADDR_W`, default 6: byte-address width; word address is `ADDR_W-2` bits.

- `clk` in 1: clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `req_valid` in 1: access request.
- `req_ready` out 1: high only in IDLE; accept = `req_valid & req_ready`.
- `req_op` in 4: lb 1000, lh 1001, lw 1010, sb 1011, lbu 1100, lhu 1101, sh 1110, sw 1111; any 0xxx is illegal.
- `req_addr` in ADDR_W: byte address.
- `req_wdata` in 32: store data, LSB-aligned.
- `rsp_valid` out 1: one-cycle completion pulse.
- `rsp_rdata` out 32: extended load data; 0 for stores and errors; holds until next `rsp_valid`.
- `rsp_err` out 1: qualifies `rsp_valid`; illegal op.
- `mem_en` out 1: memory access this cycle.
- `mem_we` out 1: write (with `mem_en`).
- `mem_be` out 4: byte enables; bit i = byte lane i.
- `mem_waddr` out ADDR_W-2: word address.
- `mem_wdata` out 32: lane-aligned write data.
- `mem_rdata` in 32: read word, valid the cycle after a read with `mem_en=1`.

## Operation
- On accept, latch op, addr, and wdata. Let o = `addr[1:0]` and size = 1/2/4 from op.
- Split when (size=2 and o=3) or (size=4 and o≠0). Word1 address = word0 + 1, wrapping mod 2^(ADDR_W-2).
- Byte enables:
  - Word0 `be` = (size mask << o) truncated to 4 bits.
  - Word1 `be` = size mask >> (4−o).
  - Size masks: 0001, 0011, 1111.
- Write data:
  - Word0 data = wdata << 8·o.
  - Word1 data = wdata >> 8·(4−o).
- Load assembly:
  - Form {hi,lo}, where hi = word1 and is 0 when not split.
  - Shift right 8·o and take 32 bits.
  - lb/lh sign-extend from bit 7/15; lbu/lhu zero-extend; lw unchanged.
- FSM states: IDLE, ISSUE0, ISSUE1, CAP, RESP.
  - IDLE: on accept, go to RESP with err for an illegal op; otherwise go to ISSUE0.
  - ISSUE0: drive word0 access. Next: ISSUE1 if split, else CAP for load, else RESP.
  - ISSUE1: drive word1 access. For loads, capture `mem_rdata` as lo. Next: CAP for load, else RESP.
  - CAP: `mem_en`=0. Capture `mem_rdata` as lo (non-split) or hi (split). Next: RESP.
  - RESP: `rsp_valid`=1 with data/err registered. Next: IDLE.
- `mem_*`, `rsp_*`, and `req_ready` are decoded from state and latched registers only. There is no combinational path from `req_*`.

## Timing
- Accept at edge T.
- `rsp_valid` timing:
  - Non-split load: T+3.
  - Split load: T+4.
  - Non-split store: T+2.
  - Split store: T+3.
  - Illegal op: T+1.
- No memory access is issued for an illegal op.
- Next accept is possible at T+(latency+1); there is no overlap.
- Reset values: `req_ready`=1 (IDLE); `rsp_valid`, `rsp_err`, `mem_en`, `mem_we`=0; `mem_be`=0; `mem_waddr`, `mem_wdata`, `rsp_rdata`=0.
- `rst` in any state → IDLE at the next edge. Latched request is discarded, and no response is issued for it.
- If a split store is reset after ISSUE0, word0 remains written; this is accepted.
- `req_valid` while not ready is ignored; the requester holds the request.
- Address wrap: lw at byte 2^ADDR_W−2 splits into the top word and word 0.

## Test plan
- Reset, then lw addr 0x04 with memory word1 = 0x8899AABB → `mem_be`=1111, waddr=1, `rsp_rdata`=0x8899AABB at T+3.
- sb addr 0x05 wdata 0x000000F0 → one write, waddr=1, be=0010, wdata=0x0000F000, `rsp_valid` at T+2.
  - Then lb at 0x05 → 0xFFFFFFF0.
  - Then lbu at 0x05 → 0x000000F0.
- sw addr 0x07 wdata 0x11223344 → two writes:
  - waddr=1, be=1000, data=0x44000000.
  - waddr=2, be=0111, data=0x00112233.
  - `rsp_valid` at T+3.
  - Then lw 0x07 → 0x11223344 at T+4.
- lh addr 0x03 with word0 = 0x80000000 and word1 = 0x000000FF → split read; lh returns 0xFFFFFF80 and lhu returns 0x0000FF80.
- Illegal op 0101 → `rsp_valid`=1 and `rsp_err`=1 at T+1, `mem_en` never asserted; `req_ready` returns at T+2.
- Assert `rst` during ISSUE1 of a split load → next cycle IDLE, `mem_en`=0, no `rsp_valid`; a new lw completes normally.
